// File: rtl/multi_cycle_pkg.sv
// Shared encodings for the multi-cycle RV32 control FSM: state codes, opcodes
// and the datapath mux selects driven by the controller.
package multi_cycle_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_FETCH  = 3'd0;
  localparam state_t ST_DECODE = 3'd1;
  localparam state_t ST_EXEC   = 3'd2;
  localparam state_t ST_MEM    = 3'd3;
  localparam state_t ST_WB     = 3'd4;
  localparam state_t ST_HALT   = 3'd5;
  localparam state_t ST_ERROR  = 3'd6;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic PC_SRC_PC4    = 1'b0;
  localparam logic PC_SRC_ALUOUT = 1'b1;

  localparam logic ALU_A_RS1   = 1'b0;
  localparam logic ALU_A_OLDPC = 1'b1;

  localparam logic [1:0] ALU_B_RS2  = 2'd0;
  localparam logic [1:0] ALU_B_IMM  = 2'd1;
  localparam logic [1:0] ALU_B_FOUR = 2'd2;

  localparam logic [1:0] ALU_OP_ADD    = 2'd0;
  localparam logic [1:0] ALU_OP_FUNCT  = 2'd1;
  localparam logic [1:0] ALU_OP_BRANCH = 2'd2;

  localparam logic [1:0] WB_ALUOUT  = 2'd0;
  localparam logic [1:0] WB_MEMDATA = 2'd1;
  localparam logic [1:0] WB_LINK    = 2'd2;

  // Successor of DECODE; JAL skips EXEC because DECODE already formed OLD_PC+imm.
  function automatic state_t decode_next(input logic [6:0] opc);
    state_t nxt;
    case (opc)
      OPC_SYSTEM: nxt = ST_HALT;
      OPC_JAL:    nxt = ST_WB;
      OPC_LUI, OPC_AUIPC, OPC_OP, OPC_OPIMM,
      OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JALR: nxt = ST_EXEC;
      default:    nxt = ST_ERROR;
    endcase
    return nxt;
  endfunction

  function automatic logic is_link(input logic [6:0] opc);
    return (opc == OPC_JAL) || (opc == OPC_JALR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts stalled memory-handshake cycles and flags the cycle in which the
// count would reach MEM_TIMEOUT without the request completing.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic busy,
  input  logic done,
  output logic expired
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start || done) begin
      cnt_d = '0;
    end else if (busy) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Expiry only on a stalled cycle, so a handshake on the last allowed cycle wins.
  assign expired = busy && !done && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Control FSM for a multi-cycle RV32I core: sequences fetch, decode, execute,
// memory and write-back, and counts retired instructions.
module multi_cycle_ctrl
  import multi_cycle_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             bcond,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op_sel,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic             is_halted,
  output logic             err,
  output logic [CNT_W-1:0] instret
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic       req_c, we_c, irw_c, pcw_c, pcs_c, asa_c, rw_c;
  logic [1:0] asb_c, aop_c, wbs_c;

  logic tmr_start, tmr_busy, tmr_done, tmr_expired;

  always_comb begin
    state_d = state_q;
    req_c   = 1'b0;
    we_c    = 1'b0;
    irw_c   = 1'b0;
    pcw_c   = 1'b0;
    pcs_c   = PC_SRC_PC4;
    asa_c   = ALU_A_RS1;
    asb_c   = ALU_B_RS2;
    aop_c   = ALU_OP_ADD;
    rw_c    = 1'b0;
    wbs_c   = WB_ALUOUT;
    case (state_q)
      ST_FETCH: begin
        req_c = 1'b1;
        if (mem_ready) begin
          irw_c   = 1'b1;
          state_d = ST_DECODE;
        end else if (tmr_expired) begin
          state_d = ST_ERROR;
        end
      end
      ST_DECODE: begin
        asa_c   = ALU_A_OLDPC;
        asb_c   = ALU_B_IMM;
        aop_c   = ALU_OP_ADD;
        state_d = decode_next(opcode);
      end
      ST_EXEC: begin
        case (opcode)
          OPC_OP: begin
            aop_c   = ALU_OP_FUNCT;
            asb_c   = ALU_B_RS2;
            state_d = ST_WB;
          end
          OPC_OPIMM: begin
            aop_c   = ALU_OP_FUNCT;
            asb_c   = ALU_B_IMM;
            state_d = ST_WB;
          end
          OPC_LOAD, OPC_STORE: begin
            asb_c   = ALU_B_IMM;
            state_d = ST_MEM;
          end
          OPC_JALR, OPC_LUI: begin
            asb_c   = ALU_B_IMM;
            state_d = ST_WB;
          end
          OPC_AUIPC: begin
            asa_c   = ALU_A_OLDPC;
            asb_c   = ALU_B_IMM;
            state_d = ST_WB;
          end
          OPC_BRANCH: begin
            aop_c   = ALU_OP_BRANCH;
            pcw_c   = 1'b1;
            pcs_c   = bcond;
            state_d = ST_FETCH;
          end
          default: state_d = ST_ERROR;
        endcase
      end
      ST_MEM: begin
        req_c = 1'b1;
        we_c  = (opcode == OPC_STORE);
        if (mem_ready) begin
          if (opcode == OPC_LOAD) begin
            state_d = ST_WB;
          end else if (opcode == OPC_STORE) begin
            pcw_c   = 1'b1;
            pcs_c   = PC_SRC_PC4;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_ERROR;
          end
        end else if (tmr_expired) begin
          state_d = ST_ERROR;
        end
      end
      ST_WB: begin
        rw_c    = 1'b1;
        pcw_c   = 1'b1;
        state_d = ST_FETCH;
        if (is_link(opcode)) begin
          wbs_c = WB_LINK;
          pcs_c = PC_SRC_ALUOUT;
        end else if (opcode == OPC_LOAD) begin
          wbs_c = WB_MEMDATA;
        end
      end
      ST_HALT, ST_ERROR: state_d = state_q;
      default: state_d = ST_ERROR;
    endcase
  end

  // Every cycle that writes the PC retires exactly one instruction.
  always_comb begin
    instret_d = instret_q;
    if (pcw_c) begin
      instret_d = instret_q + CNT_W'(1);
    end
  end

  assign tmr_start = (state_d != state_q) &&
                     ((state_d == ST_FETCH) || (state_d == ST_MEM));
  assign tmr_busy  = req_c && !mem_ready;
  assign tmr_done  = req_c && mem_ready;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clk    (clk),
    .rst_n  (reset),
    .start  (tmr_start),
    .busy   (tmr_busy),
    .done   (tmr_done),
    .expired(tmr_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  // Outputs are masked while reset is held so FETCH does not issue a request early.
  assign mem_req    = reset & req_c;
  assign mem_we     = reset & we_c;
  assign ir_write   = reset & irw_c;
  assign pc_write   = reset & pcw_c;
  assign pc_src     = reset & pcs_c;
  assign alu_src_a  = reset & asa_c;
  assign alu_src_b  = reset ? asb_c : 2'd0;
  assign alu_op_sel = reset ? aop_c : 2'd0;
  assign reg_write  = reset & rw_c;
  assign wb_sel     = reset ? wbs_c : 2'd0;
  assign is_halted  = reset & (state_q == ST_HALT);
  assign err        = reset & (state_q == ST_ERROR);
  assign instret    = instret_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed checks of the multi-cycle controller: per-cycle control vectors,
// retire counting, memory timeout boundary, halt/error and reset behaviour.
module tb_multi_cycle_ctrl;

  localparam logic [6:0] ADDI   = 7'h13;
  localparam logic [6:0] BEQ    = 7'b1100011;
  localparam logic [6:0] LW     = 7'b0000011;
  localparam logic [6:0] SW     = 7'b0100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] ROP    = 7'b0110011;
  localparam logic [6:0] ECALL  = 7'b1110011;
  localparam logic [6:0] BADOP  = 7'h7F;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic        bcond;
  logic        mem_ready;

  logic        mem_req, mem_we, ir_write, pc_write, pc_src, alu_src_a;
  logic [1:0]  alu_src_b, alu_op_sel, wb_sel;
  logic        reg_write, is_halted, err;
  logic [31:0] instret;

  logic        w4_mem_req, w4_mem_we, w4_ir_write, w4_pc_write, w4_pc_src, w4_alu_src_a;
  logic [1:0]  w4_alu_src_b, w4_alu_op_sel, w4_wb_sel;
  logic        w4_reg_write, w4_is_halted, w4_err;
  logic [3:0]  w4_instret;

  logic [14:0] ctl;
  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  multi_cycle_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .bcond(bcond), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op_sel(alu_op_sel), .reg_write(reg_write), .wb_sel(wb_sel),
    .is_halted(is_halted), .err(err), .instret(instret)
  );

  multi_cycle_ctrl #(.CNT_W(4)) dut_w4 (
    .clk(clk), .reset(reset), .opcode(opcode), .bcond(bcond), .mem_ready(mem_ready),
    .mem_req(w4_mem_req), .mem_we(w4_mem_we), .ir_write(w4_ir_write),
    .pc_write(w4_pc_write), .pc_src(w4_pc_src), .alu_src_a(w4_alu_src_a),
    .alu_src_b(w4_alu_src_b), .alu_op_sel(w4_alu_op_sel), .reg_write(w4_reg_write),
    .wb_sel(w4_wb_sel), .is_halted(w4_is_halted), .err(w4_err), .instret(w4_instret)
  );

  assign ctl = {mem_req, mem_we, ir_write, pc_write, pc_src, alu_src_a,
                alu_src_b, alu_op_sel, reg_write, wb_sel, is_halted, err};

  function automatic logic [14:0] pk(input logic mreq, input logic we, input logic irw,
                                     input logic pcw, input logic pcs, input logic asa,
                                     input logic [1:0] asb, input logic [1:0] aop,
                                     input logic rw, input logic [1:0] wb,
                                     input logic h, input logic e);
    return {mreq, we, irw, pcw, pcs, asa, asb, aop, rw, wb, h, e};
  endfunction

  localparam logic [14:0] E_ZERO  = 15'd0;
  localparam logic [14:0] E_FW    = pk(1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 2'd0, 0, 0);
  localparam logic [14:0] E_FH    = pk(1, 0, 1, 0, 0, 0, 2'd0, 2'd0, 0, 2'd0, 0, 0);
  localparam logic [14:0] E_DEC   = pk(0, 0, 0, 0, 0, 1, 2'd1, 2'd0, 0, 2'd0, 0, 0);
  localparam logic [14:0] E_XOPI  = pk(0, 0, 0, 0, 0, 0, 2'd1, 2'd1, 0, 2'd0, 0, 0);
  localparam logic [14:0] E_XOP   = pk(0, 0, 0, 0, 0, 0, 2'd0, 2'd1, 0, 2'd0, 0, 0);
  localparam logic [14:0] E_XADR  = pk(0, 0, 0, 0, 0, 0, 2'd1, 2'd0, 0, 2'd0, 0, 0);
  localparam logic [14:0] E_XAUI  = pk(0, 0, 0, 0, 0, 1, 2'd1, 2'd0, 0, 2'd0, 0, 0);
  localparam logic [14:0] E_XBT   = pk(0, 0, 0, 1, 1, 0, 2'd0, 2'd2, 0, 2'd0, 0, 0);
  localparam logic [14:0] E_XBN   = pk(0, 0, 0, 1, 0, 0, 2'd0, 2'd2, 0, 2'd0, 0, 0);
  localparam logic [14:0] E_MLD   = pk(1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 2'd0, 0, 0);
  localparam logic [14:0] E_MST   = pk(1, 1, 0, 1, 0, 0, 2'd0, 2'd0, 0, 2'd0, 0, 0);
  localparam logic [14:0] E_WALU  = pk(0, 0, 0, 1, 0, 0, 2'd0, 2'd0, 1, 2'd0, 0, 0);
  localparam logic [14:0] E_WMEM  = pk(0, 0, 0, 1, 0, 0, 2'd0, 2'd0, 1, 2'd1, 0, 0);
  localparam logic [14:0] E_WLNK  = pk(0, 0, 0, 1, 1, 0, 2'd0, 2'd0, 1, 2'd2, 0, 0);
  localparam logic [14:0] E_HALT  = pk(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 2'd0, 1, 0);
  localparam logic [14:0] E_ERR   = pk(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 2'd0, 0, 1);

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Apply inputs for one cycle, check the decoded controls, then advance.
  task automatic cyc(input string tag, input logic [6:0] op, input logic rdy,
                     input logic bc, input logic [14:0] exp);
    opcode    = op;
    mem_ready = rdy;
    bcond     = bc;
    #1;
    check(tag, 32'(ctl), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #1;
    check("rst_ctl", 32'(ctl), 32'(E_ZERO));
    check("rst_instret", instret, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset     = 1'b0;
    opcode    = ADDI;
    bcond     = 1'b0;
    mem_ready = 1'b1;
    #2;
    check("rst_hold_ctl", 32'(ctl), 32'(E_ZERO));
    check("rst_hold_instret", instret, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // ADDI: four cycles, reg_write only in WB
    cyc("addi_fetch", ADDI, 1, 0, E_FH);
    cyc("addi_dec",   ADDI, 1, 0, E_DEC);
    cyc("addi_exec",  ADDI, 1, 0, E_XOPI);
    check("addi_pre_retire", instret, 32'd0);
    cyc("addi_wb",    ADDI, 1, 0, E_WALU);
    check("addi_instret", instret, 32'd1);

    cyc("beqt_fetch", BEQ, 1, 1, E_FH);
    cyc("beqt_dec",   BEQ, 1, 1, E_DEC);
    cyc("beqt_exec",  BEQ, 1, 1, E_XBT);
    check("beqt_instret", instret, 32'd2);
    cyc("beqn_fetch", BEQ, 1, 0, E_FH);
    cyc("beqn_dec",   BEQ, 1, 0, E_DEC);
    cyc("beqn_exec",  BEQ, 1, 0, E_XBN);
    check("beqn_instret", instret, 32'd3);

    // LOAD with three stalled MEM cycles: eight cycles total
    cyc("lw_fetch", LW, 1, 0, E_FH);
    cyc("lw_dec",   LW, 1, 0, E_DEC);
    cyc("lw_exec",  LW, 1, 0, E_XADR);
    for (int i = 0; i < 3; i++) cyc("lw_mem_wait", LW, 0, 0, E_MLD);
    cyc("lw_mem_hs", LW, 1, 0, E_MLD);
    cyc("lw_wb",     LW, 1, 0, E_WMEM);
    check("lw_instret", instret, 32'd4);

    cyc("sw_fetch", SW, 1, 0, E_FH);
    cyc("sw_dec",   SW, 1, 0, E_DEC);
    cyc("sw_exec",  SW, 1, 0, E_XADR);
    cyc("sw_mem",   SW, 1, 0, E_MST);
    check("sw_instret", instret, 32'd5);

    cyc("jal_fetch", JAL, 1, 0, E_FH);
    cyc("jal_dec",   JAL, 1, 0, E_DEC);
    cyc("jal_wb",    JAL, 1, 0, E_WLNK);
    check("jal_instret", instret, 32'd6);

    cyc("jalr_fetch", JALR, 1, 0, E_FH);
    cyc("jalr_dec",   JALR, 1, 0, E_DEC);
    cyc("jalr_exec",  JALR, 1, 0, E_XADR);
    cyc("jalr_wb",    JALR, 1, 0, E_WLNK);

    cyc("lui_fetch", LUI, 1, 0, E_FH);
    cyc("lui_dec",   LUI, 1, 0, E_DEC);
    cyc("lui_exec",  LUI, 1, 0, E_XADR);
    cyc("lui_wb",    LUI, 1, 0, E_WALU);

    cyc("auipc_fetch", AUIPC, 1, 0, E_FH);
    cyc("auipc_dec",   AUIPC, 1, 0, E_DEC);
    cyc("auipc_exec",  AUIPC, 1, 0, E_XAUI);
    cyc("auipc_wb",    AUIPC, 1, 0, E_WALU);

    cyc("op_fetch", ROP, 1, 0, E_FH);
    cyc("op_dec",   ROP, 1, 0, E_DEC);
    cyc("op_exec",  ROP, 1, 0, E_XOP);
    cyc("op_wb",    ROP, 1, 0, E_WALU);
    check("op_instret", instret, 32'd10);

    // Handshake on the 15th FETCH cycle beats the timeout
    for (int i = 0; i < 14; i++) cyc("to_edge_wait", ADDI, 0, 0, E_FW);
    cyc("to_edge_hs",   ADDI, 1, 0, E_FH);
    cyc("to_edge_dec",  ADDI, 1, 0, E_DEC);
    cyc("to_edge_exec", ADDI, 1, 0, E_XOPI);
    cyc("to_edge_wb",   ADDI, 1, 0, E_WALU);
    check("to_edge_instret", instret, 32'd11);

    // Fifteen stalled FETCH cycles expire into ERROR, which then holds
    for (int i = 0; i < 15; i++) cyc("to_wait", ADDI, 0, 0, E_FW);
    for (int i = 0; i < 3; i++) cyc("to_err_hold", ADDI, 1, 1, E_ERR);
    check("to_err_instret", instret, 32'd11);
    pulse_reset();

    cyc("ecall_fetch", ECALL, 1, 0, E_FH);
    cyc("ecall_dec",   ECALL, 1, 0, E_DEC);
    for (int i = 0; i < 3; i++) cyc("ecall_halt", ADDI, 1, 1, E_HALT);
    check("ecall_instret", instret, 32'd0);
    pulse_reset();

    cyc("bad_fetch", BADOP, 1, 0, E_FH);
    cyc("bad_dec",   BADOP, 1, 0, E_DEC);
    for (int i = 0; i < 2; i++) cyc("bad_err", BADOP, 1, 0, E_ERR);
    pulse_reset();

    // Asynchronous reset in the middle of a stalled MEM request
    cyc("mr_addi_f", ADDI, 1, 0, E_FH);
    cyc("mr_addi_d", ADDI, 1, 0, E_DEC);
    cyc("mr_addi_e", ADDI, 1, 0, E_XOPI);
    cyc("mr_addi_w", ADDI, 1, 0, E_WALU);
    cyc("mr_lw_f", LW, 1, 0, E_FH);
    cyc("mr_lw_d", LW, 1, 0, E_DEC);
    cyc("mr_lw_e", LW, 1, 0, E_XADR);
    mem_ready = 1'b0;
    #1;
    check("mr_mem_req_before", 32'(mem_req), 32'd1);
    check("mr_instret_before", instret, 32'd1);
    #1;
    reset = 1'b0;
    #1;
    check("mr_mem_req_in_rst", 32'(mem_req), 32'd0);
    check("mr_ctl_in_rst", 32'(ctl), 32'(E_ZERO));
    check("mr_instret_in_rst", instret, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc("mr_resume_f", ADDI, 1, 0, E_FH);
    cyc("mr_resume_d", ADDI, 1, 0, E_DEC);
    pulse_reset();

    // Seventeen retires: 32-bit counter reads 17, 4-bit counter wraps to 1
    for (int i = 0; i < 17; i++) begin
      cyc("wrap_f", ADDI, 1, 0, E_FH);
      cyc("wrap_d", ADDI, 1, 0, E_DEC);
      cyc("wrap_e", ADDI, 1, 0, E_XOPI);
      cyc("wrap_w", ADDI, 1, 0, E_WALU);
    end
    check("wrap_instret32", instret, 32'd17);
    check("wrap_instret4", 32'(w4_instret), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
